// File: rtl/spi_slave_responder.sv
// spi_slave_responder: oversampled SPI slave with valid/ready tx and rx word handshakes.
module spi_slave_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sclk_i,
  input  logic                          ss_n_i,
  input  logic                          mosi_i,
  output logic                          miso_o,
  output logic                          miso_oe,
  input  logic [$clog2(DATA_WIDTH)-1:0] char_len,
  input  logic                          lsb,
  input  logic                          rx_negedge,
  input  logic                          tx_negedge,
  input  logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [DATA_WIDTH-1:0]         rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          tx_underrun,
  output logic                          rx_overrun,
  output logic                          frame_abort
);
  localparam int CLW = $clog2(DATA_WIDTH);
  localparam int CW  = CLW + 1;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;
  state_e state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sq, ss_sq, mosi_sq;
  logic sclk_dq, ss_dq;
  logic [CW-1:0] cnt_q, cnt_d, len_q, len_d, len_in;
  logic lsb_q, lsb_d, rxn_q, rxn_d, txn_q, txn_d;
  logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d, rx_data_q, rx_data_d;
  logic rx_valid_q, rx_valid_d, miso_q, miso_d, oe_q, oe_d;
  logic und_q, und_d, ovr_q, ovr_d, abt_q, abt_d;
  logic sclk_s, ss_s, mosi_s, rise, fall, ss_fall, ss_rise, cap, upd;

  // Bit position of the k-th transferred bit for the given order and length.
  function automatic logic [CLW-1:0] bit_idx(input logic lsbf, input logic [CW-1:0] len,
                                             input logic [CW-1:0] k);
    logic [CW-1:0] i;
    i = lsbf ? k : len - CW'(1) - k;
    return i[CLW-1:0];
  endfunction

  assign sclk_s  = sclk_sq[SYNC_STAGES-1];
  assign ss_s    = ss_sq[SYNC_STAGES-1];
  assign mosi_s  = mosi_sq[SYNC_STAGES-1];
  assign rise    = sclk_s & ~sclk_dq;
  assign fall    = ~sclk_s & sclk_dq;
  assign ss_fall = ~ss_s & ss_dq;
  assign ss_rise = ss_s & ~ss_dq;
  assign cap     = rxn_q ? fall : rise;
  assign upd     = txn_q ? fall : rise;
  assign len_in  = (char_len == '0) ? CW'(DATA_WIDTH) : {1'b0, char_len};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    lsb_d      = lsb_q;
    rxn_d      = rxn_q;
    txn_d      = txn_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q & ~rx_ready;
    miso_d     = miso_q;
    oe_d       = oe_q;
    tx_ready   = 1'b0;
    und_d      = 1'b0;
    ovr_d      = 1'b0;
    abt_d      = 1'b0;
    case (state_q)
      IDLE: state_d = ss_fall ? LOAD : IDLE;
      LOAD: begin
        len_d    = len_in;
        lsb_d    = lsb;
        rxn_d    = rx_negedge;
        txn_d    = tx_negedge;
        cnt_d    = '0;
        rx_sr_d  = '0;
        tx_sr_d  = tx_valid ? tx_data : '0;
        tx_ready = tx_valid;
        und_d    = ~tx_valid;
        miso_d   = tx_valid & tx_data[bit_idx(lsb, len_in, '0)];
        oe_d     = 1'b1;
        state_d  = SHIFT;
      end
      SHIFT: begin
        if (cnt_q == len_q) state_d = DONE;
        else begin
          if (cap) begin
            rx_sr_d[bit_idx(lsb_q, len_q, cnt_q)] = mosi_s;
            cnt_d = cnt_q + CW'(1);
          end
          // Capture is applied first so a same-edge update already sees the new count.
          if (upd && cnt_d != '0 && cnt_d != len_q) miso_d = tx_sr_q[bit_idx(lsb_q, len_q, cnt_d)];
        end
      end
      DONE: begin
        if (rx_valid_q && !rx_ready) ovr_d = 1'b1;
        else begin
          rx_data_d  = rx_sr_q;
          rx_valid_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (ss_rise) begin
      oe_d   = 1'b0;
      miso_d = 1'b0;
      if (state_q == LOAD || state_q == SHIFT) begin
        abt_d   = 1'b1;
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sclk_sq    <= '0;
      ss_sq      <= '1;
      mosi_sq    <= '0;
      sclk_dq    <= 1'b0;
      ss_dq      <= 1'b1;
      cnt_q      <= '0;
      len_q      <= '0;
      lsb_q      <= 1'b0;
      rxn_q      <= 1'b0;
      txn_q      <= 1'b0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      und_q      <= 1'b0;
      ovr_q      <= 1'b0;
      abt_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sclk_sq    <= {sclk_sq[SYNC_STAGES-2:0], sclk_i};
      ss_sq      <= {ss_sq[SYNC_STAGES-2:0], ss_n_i};
      mosi_sq    <= {mosi_sq[SYNC_STAGES-2:0], mosi_i};
      sclk_dq    <= sclk_s;
      ss_dq      <= ss_s;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      lsb_q      <= lsb_d;
      rxn_q      <= rxn_d;
      txn_q      <= txn_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      miso_q     <= miso_d;
      oe_q       <= oe_d;
      und_q      <= und_d;
      ovr_q      <= ovr_d;
      abt_q      <= abt_d;
    end
  end

  assign miso_o      = miso_q;
  assign miso_oe     = oe_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = und_q;
  assign rx_overrun  = ovr_q;
  assign frame_abort = abt_q;
endmodule
